// File: rtl/mem_wide_stream_reader.sv
// Sequential read-DMA on a wide memory-island port: fetches a contiguous run of
// wide words and streams them out, with credits sized to the output FIFO.
module mem_wide_stream_reader #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 256,
  parameter int FifoDepth = 4,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_q_valid_o,
  input  logic                 mem_q_ready_i,
  output logic [AddrWidth-1:0] mem_q_addr_o,
  input  logic                 mem_p_valid_i,
  input  logic [DataWidth-1:0] mem_p_data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0]      DepthC    = CntW'(FifoDepth);
  localparam logic [PtrW-1:0]      PtrMax    = PtrW'(FifoDepth - 1);
  localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(DataWidth / 8);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  busy_q, done_q, done_d;
  logic                  req_vld_q, req_vld_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [LenWidth-1:0]   req_left_q, req_left_d;
  logic [LenWidth-1:0]   len_q, rsp_idx_q;
  logic [CntW-1:0]       out_q, out_d, cnt_q, cnt_d;
  logic [CntW:0]         credit_sum;
  logic                  credit_ok;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                  vld_q;
  logic [DataWidth-1:0]  fifo_data_q [FifoDepth];
  logic [FifoDepth-1:0]  fifo_last_q;
  logic                  start_ok, start_zero, req_hs, push, pop, last_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  assign start_ok   = (state_q == IDLE) && start_i && (num_words_i != '0);
  assign start_zero = (state_q == IDLE) && start_i && (num_words_i == '0);
  assign req_hs     = req_vld_q && mem_q_ready_i;
  assign push       = mem_p_valid_i;
  assign pop        = vld_q && ready_i;
  assign last_pop   = pop && fifo_last_q[rd_ptr_q];

  // Credits are judged on next-cycle occupancy, so a raised request never overfills the FIFO.
  assign out_d      = out_q + CntW'(req_hs) - CntW'(push);
  assign cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
  assign credit_sum = {1'b0, out_d} + {1'b0, cnt_d};
  assign credit_ok  = credit_sum < {1'b0, DepthC};

  assign req_left_d = start_ok ? num_words_i : req_left_q - LenWidth'(req_hs);
  assign addr_d     = start_ok ? base_addr_i : (req_hs ? addr_q + WordBytes : addr_q);
  assign done_d     = start_zero || ((state_q == DRAIN) && last_pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = FETCH;
      FETCH:   if (req_hs && (req_left_q == LenWidth'(1))) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A waiting request holds until accepted; otherwise re-arm only while credits remain.
  assign req_vld_d = (req_vld_q && !mem_q_ready_i) ||
                     ((state_d == FETCH) && (req_left_d != '0) && credit_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_vld_q   <= 1'b0;
      addr_q      <= '0;
      req_left_q  <= '0;
      len_q       <= '0;
      rsp_idx_q   <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vld_q       <= 1'b0;
      fifo_last_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      req_vld_q  <= req_vld_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      vld_q      <= (cnt_d != '0);
      if (start_ok) begin
        len_q     <= num_words_i;
        rsp_idx_q <= '0;
      end else if (push) begin
        rsp_idx_q <= rsp_idx_q + 1'b1;
      end
      if (push) begin
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
        fifo_last_q[wr_ptr_q] <= (rsp_idx_q == len_q - 1'b1);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_data_q[wr_ptr_q] <= mem_p_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) assert (cnt_q != DepthC);
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign mem_q_valid_o = req_vld_q;
  assign mem_q_addr_o  = addr_q;
  assign valid_o       = vld_q;
  assign data_o        = vld_q ? fifo_data_q[rd_ptr_q] : '0;
  assign last_o        = vld_q && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_wide_stream_reader.sv
// Bench for mem_wide_stream_reader: 1-cycle memory responder, directed latency
// table, stall/backpressure/reset sequences and randomized runs against a model.
module tb_mem_wide_stream_reader;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int FD = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] num_words_i;
  logic          busy_o, done_o, mem_q_valid_o, mem_q_ready_i;
  logic [AW-1:0] mem_q_addr_o;
  logic          mem_p_valid_i;
  logic [DW-1:0] mem_p_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o, ready_i, last_o;

  always #5 clk = ~clk;

  mem_wide_stream_reader #(.AddrWidth(AW), .DataWidth(DW), .FifoDepth(FD), .LenWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o),
    .mem_q_valid_o(mem_q_valid_o), .mem_q_ready_i(mem_q_ready_i), .mem_q_addr_o(mem_q_addr_o),
    .mem_p_valid_i(mem_p_valid_i), .mem_p_data_i(mem_p_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
  );

  function automatic logic [DW-1:0] gen(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = (a * 32'h9E3779B1) ^ (32'h01010101 * 32'(k));
    return w;
  endfunction

  // Memory island stand-in: fixed 1-cycle read latency, in order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_p_valid_i <= 1'b0;
      mem_p_data_i  <= '0;
    end else begin
      mem_p_valid_i <= mem_q_valid_o && mem_q_ready_i;
      mem_p_data_i  <= gen(mem_q_addr_o);
    end
  end

  int total = 0, bad = 0;
  int cyc = 0, t0 = 0;
  logic [AW-1:0] rq_addr[$];
  int            rq_cyc[$];
  logic [DW-1:0] od[$];
  logic          ol[$];
  int            oc[$];
  int done_cnt, done_cyc, busy_cnt, qv_cnt, qstall, stab_bad = 0;
  logic          pq_v = 1'b0, pq_r = 1'b0, po_v = 1'b0, po_r = 1'b0, po_l = 1'b0;
  logic [AW-1:0] pq_a = '0;
  logic [DW-1:0] po_d = '0;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            exp_done;
  } vec_t;
  vec_t tbl[5];

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: sample at negedge, then advance to just after the next posedge.
  task automatic cycle();
    @(negedge clk);
    if (rst) begin
      pq_v = 1'b0;
      po_v = 1'b0;
    end else begin
      if (mem_q_valid_o && mem_q_ready_i) begin
        rq_addr.push_back(mem_q_addr_o);
        rq_cyc.push_back(cyc - t0);
      end
      if (valid_o && ready_i) begin
        od.push_back(data_o);
        ol.push_back(last_o);
        oc.push_back(cyc - t0);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      if (busy_o) busy_cnt++;
      if (mem_q_valid_o) qv_cnt++;
      if (pq_v && !pq_r) begin
        qstall++;
        if (!mem_q_valid_o || mem_q_addr_o !== pq_a) stab_bad++;
      end
      if (po_v && !po_r && (!valid_o || data_o !== po_d || last_o !== po_l)) stab_bad++;
      pq_v = mem_q_valid_o; pq_r = mem_q_ready_i; pq_a = mem_q_addr_o;
      po_v = valid_o; po_r = ready_i; po_d = data_o; po_l = last_o;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    rq_addr.delete(); rq_cyc.delete(); od.delete(); ol.delete(); oc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; qv_cnt = 0; qstall = 0;
  endtask

  task automatic start_run(input logic [AW-1:0] base, input int n);
    clear_logs();
    base_addr_i   = base;
    num_words_i   = LW'(n);
    mem_q_ready_i = 1'b1;
    ready_i       = 1'b1;
    start_i       = 1'b1;
    t0            = cyc;
    cycle();
    start_i       = 1'b0;
    base_addr_i   = $urandom;
    num_words_i   = LW'($urandom);
  endtask

  task automatic finish_run(input int max, input int pq, input int po);
    int k = 0;
    while (done_cnt == 0 && k < max) begin
      mem_q_ready_i = (int'($urandom_range(99)) < pq);
      ready_i       = (int'($urandom_range(99)) < po);
      cycle();
      k++;
    end
    if (done_cnt == 0) chk_i("run_timeout", 0, 1);
    mem_q_ready_i = 1'b1;
    ready_i       = 1'b1;
    cycle();
    cycle();
  endtask

  // Reference: N requests at base + i*32 mod 2^32, N words in order, last on N-1, one done.
  task automatic check_run(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    chk_i("req_count", rq_addr.size(), n);
    for (int i = 0; i < n && i < rq_addr.size(); i++) begin
      a = base + 32'(i) * 32'(DW / 8);
      chk_a("req_addr", rq_addr[i], a);
    end
    chk_i("out_count", od.size(), n);
    for (int i = 0; i < n && i < od.size(); i++) begin
      a = base + 32'(i) * 32'(DW / 8);
      chk_d("out_data", od[i], gen(a));
      chk_i("out_last", int'(ol[i]), int'(i == n - 1));
    end
    chk_i("done_pulses", done_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rb;
    int rn, hold, k;
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    mem_q_ready_i = 1'b1; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_busy", int'(busy_o), 0);
    chk_i("rst_done", int'(done_o), 0);
    chk_i("rst_qvalid", int'(mem_q_valid_o), 0);
    chk_a("rst_qaddr", mem_q_addr_o, '0);
    chk_i("rst_valid", int'(valid_o), 0);
    chk_i("rst_last", int'(last_o), 0);
    rst = 1'b0;
    cycle();
    cycle();

    tbl[0] = '{base: 32'h0000_0100, n: 4, exp_done: 7};
    tbl[1] = '{base: 32'h0000_0000, n: 1, exp_done: 4};
    tbl[2] = '{base: 32'hFFFF_FFE0, n: 2, exp_done: 5};
    tbl[3] = '{base: 32'h0000_1000, n: 0, exp_done: 1};
    tbl[4] = '{base: 32'h0000_0040, n: 7, exp_done: 10};
    for (int t = 0; t < 5; t++) begin
      start_run(tbl[t].base, tbl[t].n);
      finish_run(200, 100, 100);
      check_run(tbl[t].base, tbl[t].n);
      chk_i("done_cycle", done_cyc, tbl[t].exp_done);
      if (tbl[t].n == 0) begin
        chk_i("zero_busy", busy_cnt, 0);
        chk_i("zero_qvalid", qv_cnt, 0);
      end else begin
        for (int i = 0; i < tbl[t].n && i < rq_cyc.size(); i++) chk_i("req_cycle", rq_cyc[i], i + 1);
        for (int i = 0; i < tbl[t].n && i < oc.size(); i++) chk_i("out_cycle", oc[i], i + 3);
      end
    end

    // Stream stalled: only FifoDepth requests may go out.
    start_run(32'h0000_8000, 10);
    ready_i = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk_i("stall_req_count", rq_addr.size(), FD);
    chk_i("stall_qvalid", int'(mem_q_valid_o), 0);
    finish_run(200, 100, 100);
    check_run(32'h0000_8000, 10);

    // Memory port stalls request 2 for 5 cycles.
    start_run(32'h0000_2000, 6);
    hold = 0;
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      if (rq_addr.size() == 2 && hold < 5) begin
        mem_q_ready_i = 1'b0;
        hold++;
      end else begin
        mem_q_ready_i = 1'b1;
      end
      ready_i = 1'b1;
      cycle();
      k++;
    end
    finish_run(200, 100, 100);
    chk_i("qstall_cycles", qstall, 5);
    check_run(32'h0000_2000, 6);
    chk_i("hold_stable", stab_bad, 0);

    // Reset mid-FETCH after 3 of 8 requests.
    start_run(32'h0000_3000, 8);
    k = 0;
    while (rq_addr.size() < 3 && k < 50) begin
      cycle();
      k++;
    end
    chk_i("pre_reset_reqs", rq_addr.size(), 3);
    rst = 1'b1;
    #1;
    chk_i("mid_rst_busy", int'(busy_o), 0);
    chk_i("mid_rst_done", int'(done_o), 0);
    chk_i("mid_rst_qvalid", int'(mem_q_valid_o), 0);
    chk_a("mid_rst_qaddr", mem_q_addr_o, '0);
    chk_i("mid_rst_valid", int'(valid_o), 0);
    chk_i("mid_rst_last", int'(last_o), 0);
    chk_d("mid_rst_data", data_o, '0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    start_run(32'h0000_0500, 2);
    finish_run(200, 100, 100);
    check_run(32'h0000_0500, 2);

    for (int r = 0; r < 8; r++) begin
      rb = $urandom;
      rn = int'($urandom_range(30, 1));
      start_run(rb, rn);
      finish_run(3000, 70, 60);
      check_run(rb, rn);
    end
    chk_i("stable_under_stall", stab_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_wide_stream_reader.md
Name: mem_wide_stream_reader

Overview:
- Sequential read-DMA that sits on a direct wide port of the Ising-core L1 memory island (memory_island_wrap) and consumes its read responses.
- On a start pulse it fetches a contiguous run of wide words and streams them to the Ising core through a valid/ready interface.
- Credit-based flow control sizes the number of in-flight reads to a small output FIFO, so the memory port never needs response backpressure.

Parameters:
- AddrWidth, 32, byte-address width of the memory-island port.
- DataWidth, 256, wide word width in bits; a power of two, at least 8.
- FifoDepth, 4, output FIFO entries and the maximum number of reads in flight; at least 2.
- LenWidth, 16, width of the word-count field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  single-cycle start pulse; honoured only in IDLE.
- base_addr_i  in  AddrWidth  byte address of the first word; sampled on an accepted start.
- num_words_i  in  LenWidth  number of words to read; sampled on an accepted start.
- busy_o  out  1  high in FETCH and DRAIN.
- done_o  out  1  one-cycle pulse on completion.
- mem_q_valid_o  out  1  read request valid.
- mem_q_ready_i  in  1  memory island accepts the request.
- mem_q_addr_o  out  AddrWidth  request byte address.
- mem_p_valid_i  in  1  read response valid; cannot be stalled.
- mem_p_data_i  in  DataWidth  read response data.
- data_o  out  DataWidth  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- last_o  out  1  marks the final word of the run; qualified by valid_o.

Behaviour:
- Reset values: state IDLE; all counters and the FIFO cleared; busy_o, done_o, mem_q_valid_o, valid_o and last_o all 0; mem_q_addr_o 0.
- Reset mid-run: everything is cleared immediately. Responses still in flight in the memory island when reset releases are the integrator's responsibility; hold reset at least as long as the memory read latency.
- States:
  - IDLE: start_i with num_words_i > 0 latches the base and count and moves to FETCH. start_i with num_words_i = 0 pulses done_o in the next cycle, stays IDLE and issues no request.
  - FETCH: issues requests; moves to DRAIN in the cycle after the final request handshake.
  - DRAIN: waits for all responses and stream handshakes. After the handshake with last_o high it moves to IDLE and pulses done_o in the following cycle.
  - start_i is ignored in FETCH and DRAIN.
- Request rules:
  - Word address is base + i*(DataWidth/8), i = 0..N-1, wrapping modulo 2^AddrWidth with no error.
  - mem_q_valid_o is registered. It is asserted only when outstanding + fifo_count < FifoDepth.
  - Once mem_q_valid_o is asserted, it and mem_q_addr_o hold stable until mem_q_ready_i is seen. Credits can only grow while a request waits.
  - A request handshake increments outstanding and the address.
- Response rules:
  - Responses return in order. Each mem_p_valid_i pushes into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO is never full on a push; an assertion checks this.
  - Push, pop and request issue can occur in the same cycle. Counters update by their net effect: issue and response in the same cycle leave outstanding unchanged; push and pop in the same cycle leave fifo_count unchanged.
- Stream rules:
  - The FIFO has a registered output with no fall-through. valid_o rises the cycle after the push into an empty FIFO.
  - data_o, valid_o and last_o hold stable while valid_o && !ready_i.
  - last_o is high only on word N-1.
- Latency: with a 1-cycle memory and mem_q_ready_i and ready_i held high:
  - start at cycle 0.
  - First mem_q_valid_o at cycle 1.
  - First mem_p_valid_i at cycle 2.
  - First valid_o at cycle 3.
  - Throughput 1 word/cycle once FifoDepth >= memory latency + 2.
- Counters are LenWidth bits. The maximum run length is 2^LenWidth-1 words.

Test Plan:
- base 0x100, N=4, DataWidth 256, 1-cycle memory, both readies high -> requests at addresses 0x100, 0x120, 0x140, 0x160 in cycles 1-4; valid_o in cycles 3-6; last_o high in cycle 6 only; done_o pulse in cycle 7.
- N=0 start -> no mem_q_valid_o; done_o high exactly in cycle 1; busy_o stays 0.
- N=10, ready_i held low, FifoDepth 4 -> exactly 4 requests issued, then mem_q_valid_o low. Releasing ready_i resumes requests; all 10 data words arrive in order.
- mem_q_ready_i held low for 5 cycles on request 2 -> mem_q_valid_o and mem_q_addr_o stable throughout; no duplicate or skipped address.
- base 0xFFFF_FFE0, N=2 -> request addresses 0xFFFF_FFE0 then 0x0000_0000.
- rst_i asserted mid-FETCH after 3 of 8 words -> all outputs 0 immediately. A following start with N=2 completes normally with 2 words and a single done_o pulse.
